// File: rtl/cve2_bus_arbiter_pkg.sv
// rtl/cve2_bus_arbiter_pkg.sv - shared types and limits for the cve2 memory-port arbiter
package cve2_bus_arbiter_pkg;

    typedef enum logic {
        BusSrcInstr = 1'b0,
        BusSrcData  = 1'b1
    } bus_src_e;

    localparam int unsigned BusMaxOutstandingLimit = 4;
    localparam int unsigned BusCntW                = 3;
    localparam int unsigned BusPtrW                = 2;

    // Pointers wrap at the configured depth, which need not be a power of two.
    function automatic logic [BusPtrW-1:0] bus_ptr_next(input logic [BusPtrW-1:0] ptr,
                                                        input int unsigned depth);
        if (ptr == BusPtrW'(depth - 1)) begin
            return '0;
        end
        return ptr + BusPtrW'(1);
    endfunction

endpackage

// File: rtl/cve2_bus_src_fifo.sv
// rtl/cve2_bus_src_fifo.sv - in-order FIFO of source IDs for accepted memory transactions
module cve2_bus_src_fifo
    import cve2_bus_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  bus_src_e           data_i,
    input  logic               pop_i,
    output logic [BusCntW-1:0] count_o,
    output logic               full_o,
    output logic               empty_o,
    output bus_src_e           head_o
);

    bus_src_e           r_mem [BusMaxOutstandingLimit];
    logic [BusPtrW-1:0] r_wptr;
    logic [BusPtrW-1:0] r_rptr;
    logic [BusCntW-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (r_count == BusCntW'(Depth));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rptr];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= bus_ptr_next(r_wptr, Depth);
            end
            if (w_pop) begin
                r_rptr <= bus_ptr_next(r_rptr, Depth);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + BusCntW'(1);
                2'b01:   r_count <= r_count - BusCntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cve2_bus_arbiter.sv
// rtl/cve2_bus_arbiter.sv - merges instruction and data ports onto one req/gnt/rvalid memory port
module cve2_bus_arbiter
    import cve2_bus_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter logic        DataPriority   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o
);

    logic               r_lock;
    bus_src_e           r_lock_src;
    bus_src_e           r_last;
    bus_src_e           w_sel;
    logic               w_sel_req;
    logic               w_grant;
    logic               w_pop;
    logic [BusCntW-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    bus_src_e           w_head;

    always_comb begin
        w_sel = BusSrcInstr;
        if (r_lock) begin
            w_sel = r_lock_src;
        end else if (instr_req_i && data_req_i) begin
            if (DataPriority) begin
                w_sel = BusSrcData;
            end else begin
                w_sel = (r_last == BusSrcData) ? BusSrcInstr : BusSrcData;
            end
        end else if (data_req_i) begin
            w_sel = BusSrcData;
        end
    end

    assign w_sel_req   = (w_sel == BusSrcData) ? data_req_i : instr_req_i;
    assign mem_req_o   = w_sel_req & ~w_full;
    assign w_grant     = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_grant & (w_sel == BusSrcInstr);
    assign data_gnt_o  = w_grant & (w_sel == BusSrcData);

    // Fetches are always full-word reads.
    assign mem_we_o    = (w_sel == BusSrcData) ? data_we_i    : 1'b0;
    assign mem_be_o    = (w_sel == BusSrcData) ? data_be_i    : 4'hF;
    assign mem_addr_o  = (w_sel == BusSrcData) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (w_sel == BusSrcData) ? data_wdata_i : 32'h0;

    assign w_pop          = mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_pop & (w_head == BusSrcInstr);
    assign data_rvalid_o  = w_pop & (w_head == BusSrcData);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign busy_o = (w_count != '0) | r_lock;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock     <= 1'b0;
            r_lock_src <= BusSrcInstr;
            r_last     <= BusSrcData;
        end else begin
            // Hold the selection until the memory grants, so address and data stay stable.
            if (mem_req_o && !mem_gnt_i) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_sel;
            end else if (w_grant || (r_lock && !w_sel_req)) begin
                r_lock <= 1'b0;
            end
            if (w_grant) begin
                r_last <= w_sel;
            end
        end
    end

    cve2_bus_src_fifo #(
        .Depth (MaxOutstanding)
    ) u_src_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_grant),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_lock |-> w_sel_req)
        else $error("locked requester dropped its request before grant");

    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> !w_empty)
        else $error("memory response with no outstanding transaction");

endmodule
